// File: rtl/dco_stim_gen.sv
// Phase-accumulator stimulus generator: 5-bit code -> square-wave "VCO", reference window clock
// and the expected rising-edge count per window. Optional macro DCO_SWEEP_EN adds a code-sweep input.
module dco_stim_gen #(
  parameter int               CODE_W  = 5,
  parameter int               ACC_W   = 16,
  parameter logic [ACC_W-1:0] OFFSET  = 16'h0800,
  parameter logic [ACC_W-1:0] STEP    = 16'h0100,
  parameter int               REF_DIV = 256,
  parameter int               CNT_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
`ifdef DCO_SWEEP_EN
  input  logic              sweep,
`endif
  output logic              code_ready,
  output logic [CODE_W-1:0] code_active,
  output logic              vco_out,
  output logic              ref_out,
  output logic [CNT_W-1:0]  exp_count,
  output logic              exp_valid
);

  localparam int                REF_CW  = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
  localparam logic [REF_CW-1:0] REF_TC  = REF_CW'(REF_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [ACC_W-1:0]  r_acc;
  logic [REF_CW-1:0] r_ref_cnt;
  logic              r_ref_out;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic [CNT_W-1:0]  r_exp_count;
  logic              r_exp_valid;
  logic [CODE_W-1:0] r_code_active;
  logic [CODE_W-1:0] r_pend_code;
  logic              r_pending;

  logic [ACC_W-1:0]  w_fcw;
  logic [ACC_W:0]    w_sum;
  logic              w_wrap;
  logic              w_rise;
  logic              w_ref_tc;
  logic              w_ref_fall;
  logic [CNT_W-1:0]  w_edge_next;
  logic              w_code_ready;
  logic              w_sweep_load;
  logic              w_take;
  logic              w_apply;

  assign w_fcw    = OFFSET + (ACC_W'(r_code_active) * STEP);
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_fcw};
  assign w_wrap   = w_sum[ACC_W];
  // A vco_out rising edge is the accumulator MSB going 0 -> 1 at this clock.
  assign w_rise   = ~r_acc[ACC_W-1] & w_sum[ACC_W-1];
  assign w_ref_tc   = (r_ref_cnt == REF_TC);
  assign w_ref_fall = r_ref_out & w_ref_tc;
  assign w_edge_next = (w_rise && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

`ifdef DCO_SWEEP_EN
  assign w_sweep_load = sweep & r_exp_valid;
  assign w_code_ready = ~r_pending & ~sweep;
`else
  assign w_sweep_load = 1'b0;
  assign w_code_ready = ~r_pending;
`endif

  assign w_take  = code_valid & w_code_ready;
  // Apply only on a carry so the phase never jumps and no runt pulse appears.
  assign w_apply = r_pending & (~enable | w_wrap);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_ref_cnt   <= '0;
      r_ref_out   <= 1'b0;
      r_edge_cnt  <= '0;
      r_exp_count <= '0;
      r_exp_valid <= 1'b0;
    end else if (!enable) begin
      r_acc       <= '0;
      r_ref_cnt   <= '0;
      r_ref_out   <= 1'b0;
      r_edge_cnt  <= '0;
      r_exp_valid <= 1'b0;
    end else begin
      r_acc     <= w_sum[ACC_W-1:0];
      r_ref_cnt <= w_ref_tc ? '0 : r_ref_cnt + REF_CW'(1);
      if (w_ref_tc) begin
        r_ref_out <= ~r_ref_out;
      end
      if (w_ref_fall) begin
        r_exp_count <= w_edge_next;
        r_exp_valid <= 1'b1;
        r_edge_cnt  <= '0;
      end else begin
        r_exp_valid <= 1'b0;
        if (r_ref_out) begin
          r_edge_cnt <= w_edge_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code_active <= '0;
      r_pend_code   <= '0;
      r_pending     <= 1'b0;
    end else if (w_sweep_load) begin
      r_pend_code <= r_code_active + CODE_W'(1);
      r_pending   <= 1'b1;
    end else if (w_apply) begin
      r_code_active <= r_pend_code;
      r_pending     <= 1'b0;
    end else if (w_take) begin
      r_pend_code <= code_in;
      r_pending   <= 1'b1;
    end
  end

  assign code_ready  = w_code_ready;
  assign code_active = r_code_active;
  assign vco_out     = r_acc[ACC_W-1];
  assign ref_out     = r_ref_out;
  assign exp_count   = r_exp_count;
  assign exp_valid   = r_exp_valid;

endmodule

// File: tb/tb_dco_stim_gen.sv
// Bench for dco_stim_gen: an arithmetic phase/window model checked every cycle,
// directed literal pins from the test plan, then randomized codes, enable drops and resets.
module tb_dco_stim_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] code_in = '0;
  logic       code_valid = 1'b0;
`ifdef DCO_SWEEP_EN
  logic       sweep = 1'b0;
`endif
  logic       code_ready;
  logic [4:0] code_active;
  logic       vco_out;
  logic       ref_out;
  logic [9:0] exp_count;
  logic       exp_valid;

  int total = 0;
  int bad = 0;

  dco_stim_gen dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .code_in(code_in),
    .code_valid(code_valid),
`ifdef DCO_SWEEP_EN
    .sweep(sweep),
`endif
    .code_ready(code_ready),
    .code_active(code_active),
    .vco_out(vco_out),
    .ref_out(ref_out),
    .exp_count(exp_count),
    .exp_valid(exp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase as an integer mod 65536, window position as enabled edges mod 512.
  int m_phase = 0;
  int m_n = 0;
  int m_cnt = 0;
  int m_exp_count = 0;
  bit m_exp_valid = 0;
  int m_code = 0;
  int m_pend = 0;
  bit m_pending = 0;
  int t_sum, t_newp, t_nn;
  bit t_wrap, t_rise, t_ref_old, t_ref_new;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_n = 0; m_cnt = 0; m_exp_count = 0; m_exp_valid = 0;
      m_code = 0; m_pend = 0; m_pending = 0;
    end else begin
      t_wrap = 0;
      if (enable) begin
        t_sum     = m_phase + 2048 + 256 * m_code;
        t_wrap    = (t_sum >= 65536);
        t_newp    = t_sum % 65536;
        t_rise    = (m_phase < 32768) && (t_newp >= 32768);
        t_ref_old = (m_n >= 256);
        t_nn      = (m_n + 1) % 512;
        t_ref_new = (t_nn >= 256);
        if (t_ref_old && t_rise && m_cnt < 1023) m_cnt++;
        if (t_ref_old && !t_ref_new) begin
          m_exp_count = m_cnt; m_exp_valid = 1; m_cnt = 0;
        end else begin
          m_exp_valid = 0;
        end
        m_phase = t_newp;
        m_n = t_nn;
      end else begin
        m_phase = 0; m_n = 0; m_cnt = 0; m_exp_valid = 0;
      end
      if (m_pending) begin
        if (!enable || t_wrap) begin
          m_code = m_pend; m_pending = 0;
        end
      end else if (code_valid) begin
        m_pending = 1; m_pend = code_in;
      end
    end
  end

  // Every-cycle compare plus a minimum-pulse-width monitor while runt_en is set.
  bit   runt_en = 0;
  bit   runt_seen = 0;
  int   run_len = 0;
  logic prev_v = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("code_ready", code_ready, !m_pending);
      chk("code_active", code_active, m_code);
      chk("vco_out", vco_out, (m_phase >= 32768));
      chk("ref_out", ref_out, (m_n >= 256));
      chk("exp_count", exp_count, m_exp_count);
      chk("exp_valid", exp_valid, m_exp_valid);
      if (runt_en) begin
        if (vco_out !== prev_v) begin
          if (runt_seen) chk("pulse_ge_3", (run_len >= 3), 1);
          runt_seen = 1;
          run_len = 1;
        end else begin
          run_len++;
        end
      end else begin
        runt_seen = 0;
      end
      prev_v = vco_out;
    end
  end

  task automatic offer(input logic [4:0] c, input bit noise);
    bit rdy;
    bit done = 0;
    code_valid = 1'b1;
    code_in = c;
    for (int i = 0; i < 300 && !done; i++) begin
      rdy = code_ready;
      @(posedge clk);
      if (rdy) done = 1;
      @(negedge clk);
    end
    chk("offer_accepted", done, 1);
    if (noise) begin
      code_in = 5'($urandom_range(0, 31));
      @(negedge clk);
    end
    code_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string nm);
    bit got = 0;
    for (int i = 0; i < 1100 && !got; i++) begin
      @(posedge clk);
      #2;
      if (exp_valid) got = 1;
    end
    chk(nm, got, 1);
  endtask

  int k;
  int waited;
  int held;
  bit found;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", code_ready, 1);
    chk("rst_active", code_active, 0);
    chk("rst_vco", vco_out, 0);
    chk("rst_ref", ref_out, 0);
    chk("rst_exp_count", exp_count, 0);
    chk("rst_exp_valid", exp_valid, 0);

    // Code 0: 32-clk vco period, ref rise at 256, first window count 8 at 512
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    for (k = 1; k <= 1030; k++) begin
      @(posedge clk);
      #2;
      if (k == 15)   chk("c0_vco_k15", vco_out, 0);
      if (k == 16)   chk("c0_vco_k16", vco_out, 1);
      if (k == 32)   chk("c0_vco_k32", vco_out, 0);
      if (k == 255)  chk("c0_ref_k255", ref_out, 0);
      if (k == 256)  chk("c0_ref_k256", ref_out, 1);
      if (k == 511)  chk("c0_ev_k511", exp_valid, 0);
      if (k == 512) begin
        chk("c0_ref_k512", ref_out, 0);
        chk("c0_ev_k512", exp_valid, 1);
        chk("c0_cnt_k512", exp_count, 8);
      end
      if (k == 513)  chk("c0_ev_k513", exp_valid, 0);
      if (k == 1024) chk("c0_cnt_k1024", exp_count, 8);
    end

    // Code 31 handshake; a second offer while not ready is ignored
    @(negedge clk);
    code_valid = 1'b1;
    code_in = 5'd31;
    @(posedge clk);
    #2;
    chk("hs_ready_low", code_ready, 0);
    chk("hs_active_before_wrap", code_active, 0);
    runt_en = 1;
    @(negedge clk);
    code_in = 5'd5;
    repeat (2) @(negedge clk);
    code_valid = 1'b0;
    found = 0;
    waited = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      #2;
      waited++;
      if (code_active != 5'd0) found = 1;
    end
    chk("hs_apply_seen", found, 1);
    chk("hs_apply_cycle", waited, 23);
    chk("hs_active_31", code_active, 31);
    chk("hs_ready_back", code_ready, 1);
    wait_strobe("c31_window_strobe");
    chk("c31_count_38_39", (exp_count == 10'd38 || exp_count == 10'd39), 1);
    runt_en = 0;

    // Enable drop mid-window, then re-enable repeats post-reset timing
    repeat (100) @(negedge clk);
    held = m_exp_count;
    enable = 1'b0;
    @(posedge clk);
    #2;
    chk("dis_vco", vco_out, 0);
    chk("dis_ref", ref_out, 0);
    chk("dis_exp_hold", exp_count, held);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (k = 1; k <= 260; k++) begin
      @(posedge clk);
      #2;
      if (k == 3)   chk("reen_vco_k3", vco_out, 0);
      if (k == 4)   chk("reen_vco_k4", vco_out, 1);
      if (k == 255) chk("reen_ref_k255", ref_out, 0);
      if (k == 256) chk("reen_ref_k256", ref_out, 1);
    end

    // Reset between a handshake and its wrap discards the pending code
    @(negedge clk);
    code_valid = 1'b1;
    code_in = 5'd20;
    @(negedge clk);
    code_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_active", code_active, 0);
    chk("arst_ready", code_ready, 1);
    chk("arst_vco", vco_out, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    chk("arst_pending_dropped", code_active, 0);

    // Randomized codes, enable drops and reset pulses
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      @(negedge clk);
      if (r <= 5) begin
        offer(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else if (r <= 7) begin
        enable = 1'b0;
        if (r == 7) offer(5'($urandom_range(0, 31)), 1'b0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        enable = 1'b1;
      end else begin
        #1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 600)) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
